irq_req_sched: RTL and testbench

Per-vector interrupt request scheduler between the kernel interrupt controller and the XDMA user-interrupt port. Captures rising edges of each kernel interrupt line and presents one `usr_irq_req` per event, holding it until XDMA acknowledges. Returns the acknowledge to the interrupt controller and enforces a minimum gap between successive requests on a vector. Multiple events that arrive while a request is outstanding merge into one pending request. Keeps a per-vector count of acknowledged interrupts for status readback.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_vec_fsm.sv | 126 ++++++++++++
 rtl/irq_req_sched.sv | 39 +++
 tb/tb_irq_req_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the per-vector interrupt request scheduler.
// Optional feature macro: IRQ_RETRY_EN (request timeout and retry).
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_HOLD = 2'd2
  } irq_state_t;

  localparam int unsigned IRQ_HOLDOFF_DEF = 16;
  localparam int unsigned IRQ_TIMEOUT_DEF = 1024;
  localparam int unsigned IRQ_CNT_W_DEF   = 16;

  function automatic int unsigned irq_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/irq_vec_fsm.sv
// One interrupt vector: edge detect, pending/coalescing, IDLE/REQ/HOLD FSM,
// shared holdoff/timeout counter and acknowledged-interrupt counter.
// Optional feature macro: IRQ_RETRY_EN (re-request after TIMEOUT cycles without ack).
module irq_vec_fsm
  import irq_pkg::*;
#(
  parameter int unsigned HOLDOFF = IRQ_HOLDOFF_DEF,
  parameter int unsigned TIMEOUT = IRQ_TIMEOUT_DEF,
  parameter int unsigned CNT_W   = IRQ_CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_irq,
  input  logic             i_usr_ack,
  output logic             o_req,
  output logic             o_irq_ack,
  output logic             o_pending,
  output logic [CNT_W-1:0] o_cnt
);

  // Counter is wide enough for either the holdoff load or the retry timer.
  localparam int unsigned    CW      = $clog2(irq_max(HOLDOFF, TIMEOUT) + 1);
  localparam logic [CW-1:0]  HOLD_LD = CW'(HOLDOFF - 1);
`ifdef IRQ_RETRY_EN
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
`endif

  irq_state_t       r_state;
  logic             r_irq_d;
  logic             r_pend;
  logic             r_again;
  logic [CW-1:0]    r_cnt;
  logic             r_req;
  logic             r_irq_ack;
  logic [CNT_W-1:0] r_ack_cnt;

  irq_state_t       w_state_nxt;
  logic             w_pend_nxt;
  logic             w_again_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_ack_take;
  logic             w_rise;

  assign w_rise = i_irq & ~r_irq_d;

  // Next-state logic; r_again remembers rises seen while a request is already
  // outstanding so they survive the ack that clears the current event.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend | w_rise;
    w_again_nxt = r_again;
    w_cnt_nxt   = r_cnt;
    w_ack_take  = 1'b0;
    case (r_state)
      IRQ_IDLE: begin
        w_again_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (r_pend | w_rise) begin
          w_state_nxt = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        if (w_rise) begin
          w_again_nxt = 1'b1;
        end
        if (i_usr_ack) begin
          w_state_nxt = IRQ_HOLD;
          w_cnt_nxt   = HOLD_LD;
          w_pend_nxt  = w_rise | r_again;
          w_again_nxt = 1'b0;
          w_ack_take  = 1'b1;
        end
`ifdef IRQ_RETRY_EN
        else if (r_cnt == TMO_LAST) begin
          w_state_nxt = IRQ_HOLD;
          w_cnt_nxt   = HOLD_LD;
          w_again_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
      end
      IRQ_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = IRQ_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IRQ_IDLE;
      end
    endcase
  end

  // State, registered outputs and ack counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IRQ_IDLE;
      r_irq_d   <= 1'b0;
      r_pend    <= 1'b0;
      r_again   <= 1'b0;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_irq_ack <= 1'b0;
      r_ack_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq_d   <= i_irq;
      r_pend    <= w_pend_nxt;
      r_again   <= w_again_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req     <= (w_state_nxt == IRQ_REQ);
      r_irq_ack <= w_ack_take;
      if (w_ack_take) begin
        r_ack_cnt <= r_ack_cnt + CNT_W'(1);
      end
    end
  end

  assign o_req     = r_req;
  assign o_irq_ack = r_irq_ack;
  assign o_pending = r_pend;
  assign o_cnt     = r_ack_cnt;

endmodule

// File: rtl/irq_req_sched.sv
// Per-vector interrupt request scheduler between the kernel interrupt
// controller and the XDMA user-interrupt port. Vectors are independent.
// Optional feature macro: IRQ_RETRY_EN (request timeout and retry).
module irq_req_sched
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 2,
  parameter int unsigned HOLDOFF = IRQ_HOLDOFF_DEF,
  parameter int unsigned TIMEOUT = IRQ_TIMEOUT_DEF,
  parameter int unsigned CNT_W   = IRQ_CNT_W_DEF
) (
  input  logic                     dma_axi_aclk,
  input  logic                     dma_axi_aresetn,
  input  logic [NUM_IRQ-1:0]       irq_in,
  output logic [NUM_IRQ-1:0]       irq_in_ack,
  output logic [NUM_IRQ-1:0]       usr_irq_req,
  input  logic [NUM_IRQ-1:0]       usr_irq_ack,
  output logic [NUM_IRQ-1:0]       irq_pending,
  output logic [NUM_IRQ*CNT_W-1:0] irq_cnt
);

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_vec
    irq_vec_fsm #(
      .HOLDOFF (HOLDOFF),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_vec (
      .i_clk     (dma_axi_aclk),
      .i_rst_n   (dma_axi_aresetn),
      .i_irq     (irq_in[i]),
      .i_usr_ack (usr_irq_ack[i]),
      .o_req     (usr_irq_req[i]),
      .o_irq_ack (irq_in_ack[i]),
      .o_pending (irq_pending[i]),
      .o_cnt     (irq_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_irq_req_sched.sv
// Bench for irq_req_sched: directed scenarios plus random traffic, checked
// every cycle against a timestamp-based reference model.
module tb_irq_req_sched;

  localparam int unsigned N   = 2;
  localparam int unsigned HO  = 16;
  localparam int unsigned TMO = 8;
  localparam int unsigned CW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    irq_in;
  logic [N-1:0]    usr_ack;
  logic [N-1:0]    in_ack;
  logic [N-1:0]    req;
  logic [N-1:0]    pend;
  logic [N*CW-1:0] cnt;

  always #5 clk = ~clk;

  irq_req_sched #(
    .NUM_IRQ (N),
    .HOLDOFF (HO),
    .TIMEOUT (TMO),
    .CNT_W   (CW)
  ) dut (
    .dma_axi_aclk    (clk),
    .dma_axi_aresetn (rst_n),
    .irq_in          (irq_in),
    .irq_in_ack      (in_ack),
    .usr_irq_req     (req),
    .usr_irq_ack     (usr_ack),
    .irq_pending     (pend),
    .irq_cnt         (cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a request is outstanding or not; after it ends the
  // vector may not request again before edge m_ready.
  bit          m_req   [N];
  bit          m_ackp  [N];
  bit          m_pend  [N];
  bit          m_again [N];
  bit          m_prev  [N];
  int          m_ready [N];
  int          m_start [N];
  int unsigned m_cnt   [N];
  int          cyc_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_req[i] = 0; m_ackp[i] = 0; m_pend[i] = 0; m_again[i] = 0;
      m_prev[i] = 0; m_ready[i] = 0; m_start[i] = 0; m_cnt[i] = 0;
    end
    cyc_n = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] irq, input logic [N-1:0] ack);
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      bit rise;
      rise      = irq[i] & ~m_prev[i];
      m_prev[i] = irq[i];
      m_ackp[i] = 0;
      if (m_req[i]) begin
        if (ack[i]) begin
          m_req[i]   = 0;
          m_ackp[i]  = 1;
          m_cnt[i]   = (m_cnt[i] + 1) & ((32'd1 << CW) - 1);
          m_pend[i]  = rise | m_again[i];
          m_again[i] = 0;
          m_ready[i] = cyc_n + 1 + int'(HO);
        end else begin
          if (rise) m_again[i] = 1;
`ifdef IRQ_RETRY_EN
          if (cyc_n - m_start[i] == int'(TMO)) begin
            m_req[i]   = 0;
            m_again[i] = 0;
            m_ready[i] = cyc_n + 1 + int'(HO);
          end
`endif
        end
      end else begin
        if (rise) m_pend[i] = 1;
        if (m_pend[i] && cyc_n >= m_ready[i]) begin
          m_req[i]   = 1;
          m_start[i] = cyc_n;
          m_again[i] = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("req[%0d]@%0d", i, cyc_n), 32'(req[i]), 32'(m_req[i]));
      chk($sformatf("in_ack[%0d]@%0d", i, cyc_n), 32'(in_ack[i]), 32'(m_ackp[i]));
      chk($sformatf("pending[%0d]@%0d", i, cyc_n), 32'(pend[i]), 32'(m_pend[i]));
      chk($sformatf("cnt[%0d]@%0d", i, cyc_n), 32'(cnt[i*CW +: CW]), m_cnt[i]);
    end
  endtask

  task automatic cyc(input logic [N-1:0] irq, input logic [N-1:0] ack);
    @(negedge clk);
    irq_in  = irq;
    usr_ack = ack;
    @(posedge clk);
    model_edge(irq, ack);
    #1;
    check_outputs();
  endtask

  function automatic logic [N-1:0] model_reqs();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_req[i];
    return v;
  endfunction

  task automatic drain();
    for (int k = 0; k < 40; k++) cyc('0, model_reqs());
  endtask

  initial begin
    int n;
    logic [CW-1:0] c1;
    logic [N-1:0]  ri, ra;

    rst_n   = 1'b0;
    irq_in  = '0;
    usr_ack = '0;
    model_reset();
    #12;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_in_ack", 32'(in_ack), 32'd0);
    chk("rst_pending", 32'(pend), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single event on vector 0, acked five cycles after the rise.
    cyc(2'b01, 2'b00);
    chk("t1_req_on", 32'(req[0]), 32'd1);
    repeat (4) cyc(2'b01, 2'b00);
    cyc(2'b01, 2'b01);
    chk("t1_req_off", 32'(req[0]), 32'd0);
    chk("t1_in_ack", 32'(in_ack[0]), 32'd1);
    cyc(2'b01, 2'b00);
    chk("t1_in_ack_done", 32'(in_ack[0]), 32'd0);
    chk("t1_cnt", 32'(cnt[0 +: CW]), 32'd1);
    repeat (20) cyc(2'b00, 2'b00);

    // Coalescing: three rises on vector 1 during one request.
    cyc(2'b10, 2'b00);
    cyc(2'b00, 2'b00); cyc(2'b10, 2'b00);
    cyc(2'b00, 2'b00); cyc(2'b10, 2'b00);
    cyc(2'b00, 2'b00); cyc(2'b10, 2'b00);
    cyc(2'b10, 2'b10);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(2'b10, 2'b00);
      n++;
      if (req[1]) break;
    end
    chk("t2_gap", 32'(n), 32'(HO + 1));
    cyc(2'b10, 2'b10);
    cyc(2'b00, 2'b00);
    chk("t2_cnt", 32'(cnt[CW +: CW]), 32'd2);
    repeat (20) cyc(2'b00, 2'b00);

    // Ack and a new rise on vector 0 in the same cycle.
    cyc(2'b01, 2'b00);
    cyc(2'b00, 2'b00);
    cyc(2'b01, 2'b01);
    chk("t3_pending_kept", 32'(pend[0]), 32'd1);
    chk("t3_req_off", 32'(req[0]), 32'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(2'b01, 2'b00);
      n++;
      if (req[0]) break;
    end
    chk("t3_gap", 32'(n), 32'(HO + 1));
    cyc(2'b01, 2'b01);
    repeat (20) cyc(2'b00, 2'b00);

    // Stray ack on vector 1 while idle.
    c1 = cnt[CW +: CW];
    cyc(2'b00, 2'b10);
    chk("t4_req", 32'(req[1]), 32'd0);
    chk("t4_pending", 32'(pend[1]), 32'd0);
    cyc(2'b00, 2'b00);
    chk("t4_in_ack", 32'(in_ack[1]), 32'd0);
    chk("t4_cnt", 32'(cnt[CW +: CW]), 32'(c1));

`ifdef IRQ_RETRY_EN
    // Unacked request times out and is retried after the holdoff.
    cyc(2'b01, 2'b00);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      cyc(2'b01, 2'b00);
      if (req[0]) n++;
      else break;
    end
    chk("t5_high_len", 32'(n), 32'(TMO));
    chk("t5_no_in_ack", 32'(in_ack[0]), 32'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(2'b01, 2'b00);
      n++;
      if (req[0]) break;
    end
    chk("t5_retry_gap", 32'(n), 32'(HO + 1));
    cyc(2'b01, 2'b01);
    drain();
`endif

    // Random traffic.
    ri = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) ri[i] = ~ri[i];
        if (m_req[i]) ra[i] = ($urandom_range(5) == 0);
        else          ra[i] = ($urandom_range(39) == 0);
      end
      cyc(ri, ra);
    end
    drain();

    // Reset while vector 0 is requesting, with the line held high.
    cyc(2'b01, 2'b00);
    cyc(2'b01, 2'b00);
    chk("t6_req_before", 32'(req[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_req_async", 32'(req[0]), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2'b01, 2'b00);
    chk("t6_req_after", 32'(req[0]), 32'd1);
    cyc(2'b01, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
